// File: rtl/ciop_intr_rx.sv
// Tile-side receiver for 2-flit chip I/O bridge interrupt packets.
// Optional destination check: define CIOP_INTR_RX_DSTCHK_EN.
`ifndef MSG_DST_X
`define MSG_DST_X 49:42
`endif
`ifndef MSG_DST_Y
`define MSG_DST_Y 41:34
`endif
`ifndef MSG_LENGTH
`define MSG_LENGTH 29:22
`endif
`ifndef MSG_TYPE
`define MSG_TYPE 21:14
`endif
`ifndef MSG_TYPE_INTERRUPT
`define MSG_TYPE_INTERRUPT 8'd33
`endif

module ciop_intr_rx #(
  parameter int NOC_DATA_WIDTH = 64,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                my_x,
  input  logic [7:0]                my_y,
  input  logic                      noc_in_val,
  output logic                      noc_in_rdy,
  input  logic [NOC_DATA_WIDTH-1:0] noc_in_data,
  output logic                      intr_val,
  input  logic                      intr_rdy,
  output logic [NOC_DATA_WIDTH-1:0] intr_data,
  output logic [5:0]                intr_vec,
  output logic                      intr_err,
  output logic [CNT_WIDTH-1:0]      accept_cnt,
  output logic [CNT_WIDTH-1:0]      drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_HDR,
    S_PAY,
    S_DROP
  } state_t;

  state_t state_q, state_d;
  logic [7:0] drop_q, drop_d;
  logic       rdy_en_q;
  logic       err_q;
  logic [CNT_WIDTH-1:0] acc_q, drp_q;

  logic [NOC_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  logic [7:0] hdr_type, hdr_len;
  logic       dst_ok, hdr_good;
  logic       xfer, push, pop, bad_hdr;
  logic       fifo_full, fifo_empty;

  assign hdr_type = noc_in_data[`MSG_TYPE];
  assign hdr_len  = noc_in_data[`MSG_LENGTH];

`ifdef CIOP_INTR_RX_DSTCHK_EN
  assign dst_ok = (noc_in_data[`MSG_DST_X] == my_x) &&
                  (noc_in_data[`MSG_DST_Y] == my_y);
`else
  logic unused_dst;
  assign unused_dst = ^{my_x, my_y};
  assign dst_ok     = 1'b1;
`endif

  assign hdr_good = (hdr_type == `MSG_TYPE_INTERRUPT) &&
                    (hdr_len == 8'd1) && dst_ok;

  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);

  // no full bypass: a pop in the same cycle does not reopen the input
  assign noc_in_rdy = (state_q == S_PAY) ? !fifo_full : rdy_en_q;
  assign xfer       = noc_in_val && noc_in_rdy;

  assign intr_val = !fifo_empty;
  assign pop      = intr_val && intr_rdy;
  assign intr_data = intr_val ? mem_q[rd_q] : '0;
  assign intr_vec  = intr_data[5:0];

  assign intr_err   = err_q;
  assign accept_cnt = acc_q;
  assign drop_cnt   = drp_q;

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    push    = 1'b0;
    bad_hdr = 1'b0;
    unique case (state_q)
      S_HDR: begin
        if (xfer) begin
          if (hdr_good) begin
            state_d = S_PAY;
          end else begin
            bad_hdr = 1'b1;
            if (hdr_len != 8'd0) begin
              state_d = S_DROP;
              drop_d  = hdr_len;
            end
          end
        end
      end
      S_PAY: begin
        if (xfer) begin
          push    = 1'b1;
          state_d = S_HDR;
        end
      end
      S_DROP: begin
        if (xfer) begin
          drop_d = drop_q - 8'd1;
          if (drop_q == 8'd1) state_d = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_HDR;
      drop_q   <= '0;
      rdy_en_q <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      drp_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      rdy_en_q <= 1'b1;
      err_q    <= bad_hdr;
      if (push) begin
        acc_q <= acc_q + 1'b1;
        wr_q  <= wr_q + 1'b1;
      end
      if (bad_hdr && (drp_q != '1)) drp_q <= drp_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= noc_in_data;
  end

endmodule

// File: tb/tb_ciop_intr_rx.sv
// Self-checking bench for ciop_intr_rx: vector table, corner
// sequences and randomized packets against a packet-level model.
module tb_ciop_intr_rx;

  localparam logic [7:0] T_INTR = 8'd33;
  localparam logic [7:0] MY_X   = 8'd1;
  localparam logic [7:0] MY_Y   = 8'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  my_x, my_y;
  logic        noc_in_val;
  logic        noc_in_rdy;
  logic [63:0] noc_in_data;
  logic        intr_val;
  logic        intr_rdy;
  logic [63:0] intr_data;
  logic [5:0]  intr_vec;
  logic        intr_err;
  logic [7:0]  accept_cnt, drop_cnt;

  always #5 clk = ~clk;

  ciop_intr_rx dut (
    .clk(clk), .rst_n(rst_n), .my_x(my_x), .my_y(my_y),
    .noc_in_val(noc_in_val), .noc_in_rdy(noc_in_rdy),
    .noc_in_data(noc_in_data), .intr_val(intr_val),
    .intr_rdy(intr_rdy), .intr_data(intr_data),
    .intr_vec(intr_vec), .intr_err(intr_err),
    .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] expq[$];
  int acc_m = 0, drop_m = 0, err_m = 0;
  int err_seen = 0, pop_cnt = 0;
  int rdy_mode = 0;
  bit pay_phase = 0;

  typedef struct {
    logic [7:0]  t, l, x, y;
    logic [63:0] pay;
    bit          good;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input logic [7:0] t, l, x, y);
    logic [63:0] h;
    h = '0;
    h[49:42] = x;
    h[41:34] = y;
    h[29:22] = l;
    h[21:14] = t;
    return h;
  endfunction

  function automatic bit is_good(input logic [7:0] t, l, x, y);
    bit g;
    g = (t == T_INTR) && (l == 8'd1);
`ifdef CIOP_INTR_RX_DSTCHK_EN
    g = g && (x == MY_X) && (y == MY_Y);
`endif
    return g;
  endfunction

  // consumer: decides intr_rdy each cycle and scores every pop
  initial begin
    logic r;
    logic [63:0] e;
    intr_rdy = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      case (rdy_mode)
        0: r = 1'b0;
        1: r = 1'b1;
        2: r = 1'($urandom % 2);
        default: r = pay_phase && noc_in_val && noc_in_rdy;
      endcase
      intr_rdy = r;
      if (intr_val && r) begin
        pop_cnt++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none",
                   intr_data);
        end else begin
          e = expq.pop_front();
          chk("intr_data", intr_data, e);
          chk("intr_vec", 64'(intr_vec), 64'(e[5:0]));
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (intr_err === 1'b1) err_seen++;
  end

  task automatic send_flit(input logic [63:0] d, input bit pay);
    int n;
    n = 0;
    @(negedge clk);
    noc_in_val  = 1'b1;
    noc_in_data = d;
    pay_phase   = pay;
    while (!noc_in_rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL flit_timeout: got rdy=0 expected rdy=1");
    end
    @(posedge clk);
    #1;
    noc_in_val = 1'b0;
    pay_phase  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] t, l, x, y,
                          input logic [63:0] pay, input bit good);
    send_flit(mk_hdr(t, l, x, y), 1'b0);
    if (good) begin
      send_flit(pay, 1'b1);
      expq.push_back(pay);
      acc_m = (acc_m + 1) % 256;
    end else begin
      err_m++;
      if (drop_m < 255) drop_m++;
      for (int i = 0; i < int'(l); i++)
        send_flit({$urandom, $urandom}, 1'b0);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || intr_val) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d left expected 0",
               expq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_counters(input string nm);
    chk({nm, "_accept"}, 64'(accept_cnt), 64'(acc_m));
    chk({nm, "_drop"}, 64'(drop_cnt), 64'(drop_m));
    chk({nm, "_err"}, 64'(err_seen), 64'(err_m));
  endtask

  initial begin
    int p0;
    logic [7:0] t, l, x, y;
    logic [63:0] d;

    tbl[0] = '{T_INTR, 8'd1, MY_X, MY_Y, 64'h1111_2222_3333_4401, 1'b1};
    tbl[1] = '{8'd5,   8'd3, MY_X, MY_Y, 64'h0, 1'b0};
    tbl[2] = '{T_INTR, 8'd1, MY_X, MY_Y, 64'hAAAA_5555_0000_0015, 1'b1};
    tbl[3] = '{T_INTR, 8'd0, MY_X, MY_Y, 64'h0, 1'b0};
    tbl[4] = '{T_INTR, 8'd2, MY_X, MY_Y, 64'h0, 1'b0};
`ifdef CIOP_INTR_RX_DSTCHK_EN
    tbl[5] = '{T_INTR, 8'd1, 8'd0, 8'd0, 64'h0BAD_0000_0000_0007, 1'b0};
`else
    tbl[5] = '{T_INTR, 8'd1, 8'd0, 8'd0, 64'h0BAD_0000_0000_0007, 1'b1};
`endif
    tbl[6] = '{8'hFF,  8'd1, MY_X, MY_Y, 64'h0, 1'b0};
    tbl[7] = '{T_INTR, 8'd1, MY_X, MY_Y, 64'hFFFF_0000_FFFF_003F, 1'b1};

    my_x = MY_X;
    my_y = MY_Y;
    rst_n = 1'b0;
    noc_in_val = 1'b0;
    noc_in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 64'(noc_in_rdy), 64'd0);
    chk("rst_val", 64'(intr_val), 64'd0);
    chk("rst_data", intr_data, 64'd0);
    chk("rst_vec", 64'(intr_vec), 64'd0);
    chk("rst_err", 64'(intr_err), 64'd0);
    chk_counters("rst");
    rst_n = 1'b1;
    chk("rdy_before_edge", 64'(noc_in_rdy), 64'd0);
    @(negedge clk);
    chk("rdy_after_rst", 64'(noc_in_rdy), 64'd1);

    // single packet, one-cycle valid
    rdy_mode = 1;
    send_flit(mk_hdr(T_INTR, 8'd1, MY_X, MY_Y), 1'b0);
    send_flit(64'hDEAD_BEEF_0000_0123, 1'b1);
    expq.push_back(64'hDEAD_BEEF_0000_0123);
    acc_m = 1;
    @(negedge clk);
    chk("t1_val", 64'(intr_val), 64'd1);
    chk("t1_data", intr_data, 64'hDEAD_BEEF_0000_0123);
    chk("t1_vec", 64'(intr_vec), 64'h23);
    @(negedge clk);
    chk("t1_val_off", 64'(intr_val), 64'd0);
    chk("t1_acc", 64'(accept_cnt), 64'd1);

    // vector table
    for (int i = 0; i < 8; i++) begin
      send_pkt(tbl[i].t, tbl[i].l, tbl[i].x, tbl[i].y,
               tbl[i].pay, tbl[i].good);
      wait_drain();
      chk_counters($sformatf("vec%0d", i));
    end

    // full FIFO backpressure then ordered drain
    rdy_mode = 0;
    p0 = pop_cnt;
    for (int i = 0; i < 4; i++)
      send_pkt(T_INTR, 8'd1, MY_X, MY_Y, 64'hF0 + 64'(i), 1'b1);
    send_flit(mk_hdr(T_INTR, 8'd1, MY_X, MY_Y), 1'b0);
    @(negedge clk);
    noc_in_val = 1'b1;
    noc_in_data = 64'hF4;
    chk("full_rdy", 64'(noc_in_rdy), 64'd0);
    repeat (3) @(negedge clk);
    chk("full_rdy_hold", 64'(noc_in_rdy), 64'd0);
    chk("full_acc", 64'(accept_cnt), 64'(acc_m));
    noc_in_val = 1'b0;
    rdy_mode = 1;
    send_flit(64'hF4, 1'b1);
    expq.push_back(64'hF4);
    acc_m = (acc_m + 1) % 256;
    wait_drain();
    chk("full_pops", 64'(pop_cnt - p0), 64'd5);
    chk_counters("full");

    // reset between header and payload
    send_flit(mk_hdr(T_INTR, 8'd1, MY_X, MY_Y), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acc_m = 0;
    drop_m = 0;
    chk("mid_rst_acc", 64'(accept_cnt), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    chk("mid_rst_val", 64'(intr_val), 64'd0);
    chk("mid_rst_rdy", 64'(noc_in_rdy), 64'd0);
    d = 64'hDEAD_BEEF_0000_0123;
    send_flit(d, 1'b0);
    err_m++;
    drop_m = 1;
    send_pkt(T_INTR, 8'd1, MY_X, MY_Y, 64'h5A5A_0000_0000_0009, 1'b1);
    wait_drain();
    chk_counters("mid_rst");

    // steady occupancy of 3 with push+pop together
    rdy_mode = 0;
    for (int i = 0; i < 3; i++)
      send_pkt(T_INTR, 8'd1, MY_X, MY_Y, 64'h300 + 64'(i), 1'b1);
    p0 = pop_cnt;
    rdy_mode = 3;
    for (int i = 0; i < 10; i++)
      send_pkt(T_INTR, 8'd1, MY_X, MY_Y, 64'h400 + 64'(i), 1'b1);
    rdy_mode = 0;
    @(negedge clk);
    chk("steady_pops", 64'(pop_cnt - p0), 64'd10);
    chk("steady_val", 64'(intr_val), 64'd1);
    send_pkt(T_INTR, 8'd1, MY_X, MY_Y, 64'h500, 1'b1);
    send_flit(mk_hdr(T_INTR, 8'd1, MY_X, MY_Y), 1'b0);
    @(negedge clk);
    chk("steady_full", 64'(noc_in_rdy), 64'd0);
    rdy_mode = 1;
    send_flit(64'h501, 1'b1);
    expq.push_back(64'h501);
    acc_m = (acc_m + 1) % 256;
    wait_drain();
    chk_counters("steady");

    // randomized packets against the model
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      t = ($urandom % 4 == 0) ? 8'($urandom) : T_INTR;
      l = ($urandom % 2 == 0) ? 8'd1 : 8'($urandom % 4);
      x = ($urandom % 4 == 0) ? 8'($urandom % 3) : MY_X;
      y = ($urandom % 4 == 0) ? 8'($urandom % 3) : MY_Y;
      send_pkt(t, l, x, y, {$urandom, $urandom}, is_good(t, l, x, y));
    end
    wait_drain();
    chk_counters("random");

    // drop counter saturation
    rdy_mode = 1;
    for (int i = 0; i < 260; i++)
      send_pkt(8'd0, 8'd0, MY_X, MY_Y, 64'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("drop_sat", 64'(drop_cnt), 64'hFF);
    chk_counters("sat");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
